updown_counter: RTL
===================

# updown_counter

Parametrised up/down counter with programmable count window, wrap or saturate mode, synchronous clear and load, and a registered bound-event pulse. It replaces fixed 16-bit up/down counters in the project datapath: switch-driven counters, display value sources and event tallies. Every counting decision is made in a single clock domain with one registered state word.

## Interface
Parameters:
- WIDTH, 16: counter width in bits (2..32).
- STEP, 1: increment/decrement magnitude per counting edge (1..2^(WIDTH-1)).
- RST_VAL, 0: value of q after reset; WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- incr  in  1  count enable for this cycle.
- uphdnl  in  1  direction: 1 counts up, 0 counts down.
- sat_mode  in  1  1 saturates at the bounds, 0 wraps to the opposite bound.
- limit_lo  in  WIDTH  inclusive lower bound, unsigned.
- limit_hi  in  WIDTH  inclusive upper bound, unsigned.
- q  out  WIDTH  registered count.
- bnd  out  1  registered one-cycle pulse marking a bound event.
- at_hi  out  1  combinational: q == limit_hi.
- at_lo  out  1  combinational: q == limit_lo.
- cfg_err  out  1  combinational: limit_lo > limit_hi.

## Operation
Priority on each rising clk edge, highest first:
- clr: q <= limit_lo, bnd <= 0.
- load: q <= load_val verbatim, with no range check; bnd <= 0.
- incr with cfg_err=1: q holds, bnd <= 0. Counting is blocked while the window is invalid.
- incr with cfg_err=0: count as described below.
- Otherwise q holds and bnd <= 0.

Count arithmetic is computed at WIDTH+1 bits, so no intermediate result wraps modulo 2^WIDTH.
- Up: nxt = q + STEP.
  - If nxt <= limit_hi: q <= nxt, bnd <= 0.
  - Otherwise, a bound event: q <= (sat_mode ? limit_hi : limit_lo), bnd <= 1.
- Down: the count is in range if q >= limit_lo + STEP, computed at WIDTH+1 bits.
  - In range: q <= q - STEP, bnd <= 0.
  - Otherwise, a bound event: q <= (sat_mode ? limit_lo : limit_hi), bnd <= 1.
- A q outside the window (after a load or a limit change) is handled by the same rules. Up from above limit_hi or down from below limit_lo is a bound event, and the first count returns q into the window.
- In saturate mode, each further count attempt against the bound re-asserts bnd while q stays at the bound. bnd is therefore high continuously while incr is held against the bound.
- at_hi, at_lo and cfg_err are pure decodes with no state.

## Timing
- Reset (rst_n=0, asynchronous assert): q = RST_VAL, bnd = 0. Deassertion takes effect at the first clk edge with rst_n=1; the integrator synchronises rst_n upstream.
- Reset mid-count overrides every input immediately. No partial update survives.
- Latency: one clk from an incr, load or clr sample to q and bnd. bnd aligns with the q update that produced it.
- Inputs are sampled on the edge, and limits are read at that same edge. A limit change takes effect on the next counting edge.
- Simultaneous clr and load: clr wins. Simultaneous load and incr: load wins and the count is dropped.
- uphdnl or sat_mode changing between cycles is legal. There is no hidden direction state.

## Configuration
- Macro UPDOWN_COUNTER_SAT_EN.
- Defined: sat_mode is honoured as described above.
- Undefined: saturate logic is compiled out and sat_mode is ignored. All bound events wrap (up goes to limit_lo, down goes to limit_hi), and bnd still pulses on every wrap.

## Test plan
WIDTH=16, STEP=1, RST_VAL=0 unless noted.
- Reset: rst_n=0 asynchronously mid-cycle while q=0x1234 -> q=0x0000 and bnd=0 before the next edge; q holds through the edges while rst_n=0.
- Up wrap: limits 0x0003..0x0007, sat_mode=0, clr, then incr=1, uphdnl=1 for 6 edges -> q=4,5,6,7,3,4; bnd=1 only on the edge where q becomes 3; at_hi=1 while q=7.
- Down saturate (macro defined): load 0x0005, limits 0x0004..0x00FF, sat_mode=1, uphdnl=0, incr for 3 edges -> q=4,4,4; bnd=0,1,1.
- Priority: clr=1, load=1, load_val=0xBEEF, incr=1 -> q=limit_lo. Then load=1, incr=1 -> q=0xBEEF with no count applied. Then clr=0, load=0, incr=0 -> q holds.
- Out-of-window and large step: STEP=4, limits 0x0010..0x0020, load 0x0030, sat_mode=0, up 1 edge -> q=0x0010, bnd=1. Then down 1 edge from 0x0010 -> q=0x0020, bnd=1.
- Invalid window: limit_lo=0x0009, limit_hi=0x0002 -> cfg_err=1; incr for 4 edges leaves q unchanged and bnd=0. Restoring the limits clears cfg_err and counting resumes on the next edge.

Source files
------------

// File: rtl/updown_counter.sv
// Windowed up/down counter with programmable bounds, wrap/saturate bound handling and a bound-event pulse.
// Define UPDOWN_COUNTER_SAT_EN to honour sat_mode; without it every bound event wraps.
module updown_counter #(
    parameter int unsigned      WIDTH   = 16,
    parameter int unsigned      STEP    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             incr,
    input  logic             uphdnl,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit_lo,
    input  logic [WIDTH-1:0] limit_hi,
    output logic [WIDTH-1:0] q,
    output logic             bnd,
    output logic             at_hi,
    output logic             at_lo,
    output logic             cfg_err
);

    // One extra bit keeps q+STEP and limit_lo+STEP from wrapping before the compare.
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] q_q, q_d;
    logic             bnd_q, bnd_d;
    logic [WIDTH:0]   up_nxt;
    logic [WIDTH:0]   dn_floor;
    logic             sat_eff;

    function automatic logic [WIDTH-1:0] bound_sel(
        input logic             sat,
        input logic [WIDTH-1:0] near_bound,
        input logic [WIDTH-1:0] far_bound
    );
        return sat ? near_bound : far_bound;
    endfunction

`ifdef UPDOWN_COUNTER_SAT_EN
    assign sat_eff = sat_mode;
`else
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign sat_eff         = 1'b0;
`endif

    assign cfg_err = (limit_lo > limit_hi);
    assign at_hi   = (q_q == limit_hi);
    assign at_lo   = (q_q == limit_lo);
    assign q       = q_q;
    assign bnd     = bnd_q;

    always_comb begin
        up_nxt   = {1'b0, q_q} + STEP_X;
        dn_floor = {1'b0, limit_lo} + STEP_X;
        q_d      = q_q;
        bnd_d    = 1'b0;
        if (clr) begin
            q_d = limit_lo;
        end else if (load) begin
            q_d = load_val;
        end else if (incr && !cfg_err) begin
            if (uphdnl) begin
                if (up_nxt <= {1'b0, limit_hi}) begin
                    q_d = up_nxt[WIDTH-1:0];
                end else begin
                    q_d   = bound_sel(sat_eff, limit_hi, limit_lo);
                    bnd_d = 1'b1;
                end
            end else begin
                if ({1'b0, q_q} >= dn_floor) begin
                    q_d = q_q - STEP_X[WIDTH-1:0];
                end else begin
                    q_d   = bound_sel(sat_eff, limit_lo, limit_hi);
                    bnd_d = 1'b1;
                end
            end
        end
    end

    // Register stage: count word and bound pulse update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RST_VAL;
            bnd_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            bnd_q <= bnd_d;
        end
    end

endmodule
